// File: rtl/seq_multiplier_pkg.sv
// Shared CPU definitions used by the sequential multiplier.
package seq_multiplier_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier: one iteration per clock, registered product
// and a one-cycle mult_done pulse after WIDTH iterations.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mult_ld,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] product,
  output logic               mult_done,
  output logic               busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  mult_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [2*WIDTH-1:0] product_q;

  logic             accept, last_iter;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] acc_nx, mplier_nx;

  // Carry of the partial sum lands in acc MSB after the right shift.
  always_comb begin
    sum       = mplier_q[0] ? ({1'b0, acc_q} + {1'b0, mcand_q}) : {1'b0, acc_q};
    acc_nx    = sum[WIDTH:1];
    mplier_nx = {sum[0], mplier_q[WIDTH-1:1]};
  end

  assign accept    = (state_q != RUN) && mult_ld;
  assign last_iter = (state_q == RUN) && (cnt_q == CNT_W'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (mult_ld) begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (last_iter) state_d = DONE;
      end
      DONE: begin
        state_d = mult_ld ? RUN : IDLE;
        if (mult_ld) cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      product_q <= '0;
    end else if (accept) begin
      mcand_q  <= op_a;
      mplier_q <= op_b;
      acc_q    <= '0;
    end else if (state_q == RUN) begin
      acc_q    <= acc_nx;
      mplier_q <= mplier_nx;
      if (last_iter) product_q <= {acc_nx, mplier_nx};
    end
  end

  assign product   = product_q;
  assign busy      = (state_q == RUN);
  assign mult_done = (state_q == DONE);

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier against a plain a*b reference with
// a fixed WIDTH-edge completion latency.
module tb_seq_multiplier;

  localparam int unsigned W = 16;

  logic           clk;
  logic           rst;
  logic           mult_ld;
  logic [W-1:0]   op_a, op_b;
  logic [2*W-1:0] product;
  logic           mult_done;
  logic           busy;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [2*W-1:0] last_prod;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mult_ld   (mult_ld),
    .op_a      (op_a),
    .op_b      (op_b),
    .product   (product),
    .mult_done (mult_done),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] wa, wb;
    wa = {{W{1'b0}}, a};
    wb = {{W{1'b0}}, b};
    return wa * wb;
  endfunction

  // Present operands and let edge 0 accept them.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    op_a    = a;
    op_b    = b;
    mult_ld = 1'b1;
    @(posedge clk); #1;
    check("busy_after_accept", 64'(busy), 64'd1);
    check("done_after_accept", 64'(mult_done), 64'd0);
  endtask

  // Edges 1..last_k after acceptance; completion expected exactly at edge W.
  task automatic run_phase(input logic [2*W-1:0] want, input int pulse_at,
                           input bit hold, input int last_k);
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      if (!hold) begin
        mult_ld = (k == pulse_at);
        op_a    = (k == pulse_at) ? W'(7) : W'($urandom);
        op_b    = (k == pulse_at) ? W'(7) : W'($urandom);
      end
      @(posedge clk); #1;
      if (k < int'(W)) begin
        check("busy_run", 64'(busy), 64'd1);
        check("done_run", 64'(mult_done), 64'd0);
        check("product_hold", 64'(product), 64'(last_prod));
      end else begin
        check("done_pulse", 64'(mult_done), 64'd1);
        check("busy_done", 64'(busy), 64'd0);
        check("product", 64'(product), 64'(want));
        last_prod = want;
      end
    end
  endtask

  task automatic finish_idle();
    @(negedge clk);
    mult_ld = 1'b0;
    @(posedge clk); #1;
    check("done_drop", 64'(mult_done), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("product_keep", 64'(product), 64'(last_prod));
  endtask

  task automatic do_mult(input logic [W-1:0] a, input logic [W-1:0] b, input int pulse_at);
    start(a, b);
    run_phase(ref_mul(a, b), pulse_at, 1'b0, int'(W));
    finish_idle();
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst = 1'b0; mult_ld = 1'b0; op_a = '0; op_b = '0;
    last_prod = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_product", 64'(product), 64'd0);
    check("rst_done", 64'(mult_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk); rst = 1'b1;

    do_mult(16'd3, 16'd5, 0);
    do_mult(16'hFFFF, 16'hFFFF, 0);
    do_mult(16'h0000, 16'h1234, 0);
    do_mult(16'h1234, 16'h0000, 0);
    do_mult(16'h00FF, 16'h0100, 5);   // mid-run 7*7 pulse must be ignored

    // Back-to-back with mult_ld held high.
    start(16'd2, 16'd3);
    run_phase(ref_mul(16'd2, 16'd3), 0, 1'b1, int'(W));
    @(negedge clk); op_a = 16'd4; op_b = 16'd5;
    @(posedge clk); #1;
    check("b2b_done_drop", 64'(mult_done), 64'd0);
    check("b2b_accept", 64'(busy), 64'd1);
    run_phase(ref_mul(16'd4, 16'd5), 0, 1'b1, int'(W));
    finish_idle();

    // Asynchronous reset mid-operation.
    start(16'd9, 16'd9);
    run_phase(ref_mul(16'd9, 16'd9), 0, 1'b0, 8);
    #2 rst = 1'b0;
    #1;
    check("arst_product", 64'(product), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(mult_done), 64'd0);
    last_prod = '0;
    repeat (3) begin
      @(posedge clk); #1;
      check("arst_hold_done", 64'(mult_done), 64'd0);
    end
    @(negedge clk); rst = 1'b1;
    repeat (W + 2) begin
      @(posedge clk); #1;
      check("post_rst_no_done", 64'(mult_done), 64'd0);
    end
    do_mult(16'd9, 16'd9, 0);

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 5 == 0) ra = '1;
      if (i % 7 == 0) rb = '1;
      do_mult(ra, rb, (i % 3 == 0) ? int'($urandom_range(1, W - 1)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
